// File: rtl/count_ctrl_if.sv
// Button/switch inputs and counter-facing strobes of the BCD counter sequencer.
// The bench drives through master; the sequencer attaches through slave.
interface count_ctrl_if;
  logic        btn_start;
  logic        btn_load;
  logic [1:0]  mode;
  logic [15:0] count_value;
  logic        enable;
  logic        load_preset;
  logic        addsub;
  logic [1:0]  mode_out;
  logic        done;
  logic [2:0]  state;

  modport master (
    output btn_start, btn_load, mode, count_value,
    input  enable, load_preset, addsub, mode_out, done, state
  );

  modport slave (
    input  btn_start, btn_load, mode, count_value,
    output enable, load_preset, addsub, mode_out, done, state
  );
endinterface

// File: rtl/count_ctrl.sv
// Sequencer for a 4-digit BCD up/down counter: button synchronisation, load/run/pause
// control, tick pacing and terminal-count stop.

// One raw button -> one clk-wide pulse on each synchronised rising edge.
module count_ctrl_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  // [0],[1] metastability chain, [2] previous synced level for edge detect
  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= {sh_q[1:0], btn_i};
  end

  assign pulse_o = sh_q[1] & ~sh_q[2];
endmodule

module count_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int HOLD     = 4
) (
  input  logic         clk,
  input  logic         reset,
  count_ctrl_if.slave  bus
);
  localparam int NBTN = 2;
  localparam int TW   = $clog2(TICK_DIV);
  localparam int HW   = $clog2(HOLD + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  logic [NBTN-1:0] btn_raw, btn_pls;
  logic            start_p, load_p;

  assign btn_raw = {bus.btn_load, bus.btn_start};

  for (genvar g = 0; g < NBTN; g++) begin : g_sync
    count_ctrl_btn_sync u_sync (
      .clk     (clk),
      .rst_n   (reset),
      .btn_i   (btn_raw[g]),
      .pulse_o (btn_pls[g])
    );
  end

  assign start_p = btn_pls[0];
  assign load_p  = btn_pls[1];

  state_t          state_q;
  logic [TW-1:0]   tick_q;
  logic [HW-1:0]   hold_q;
  logic            en_q, lp_q, addsub_q, done_q;
  logic [1:0]      mode_out_q;

  logic at_wrap, terminal, go_load;

  assign at_wrap  = (tick_q == TICK_LAST);
  // Only exact BCD end values stop the count; anything else keeps going.
  assign terminal = addsub_q ? (bus.count_value == 16'h9999)
                             : (bus.count_value == 16'h0000);
  // Load is honoured everywhere except while a load is already in flight.
  assign go_load  = load_p && (state_q != S_LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      hold_q     <= '0;
      en_q       <= 1'b0;
      lp_q       <= 1'b0;
      addsub_q   <= 1'b1;
      done_q     <= 1'b0;
      mode_out_q <= 2'b00;
    end else begin
      // An enable strobe finishes its hold even after RUN->PAUSE.
      if (en_q) begin
        if (hold_q == '0) en_q   <= 1'b0;
        else              hold_q <= hold_q - HW'(1);
      end

      if (go_load) begin
        state_q    <= S_LOAD;
        lp_q       <= 1'b1;
        en_q       <= 1'b0;
        hold_q     <= HOLD_LAST;
        tick_q     <= '0;
        done_q     <= 1'b0;
        mode_out_q <= bus.mode;
        addsub_q   <= ~bus.mode[1];
      end else begin
        case (state_q)
          S_IDLE: ;
          S_LOAD: begin
            if (hold_q == '0) begin
              lp_q    <= 1'b0;
              state_q <= S_PAUSE;
            end else begin
              hold_q <= hold_q - HW'(1);
            end
          end
          S_PAUSE: begin
            if (start_p) state_q <= S_RUN;
          end
          S_RUN: begin
            if (start_p) begin
              state_q <= S_PAUSE;
            end else if (at_wrap) begin
              tick_q <= '0;
              if (terminal) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                en_q    <= 1'b0;
              end else begin
                en_q   <= 1'b1;
                hold_q <= HOLD_LAST;
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
          S_DONE: en_q <= 1'b0;
          default: begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            lp_q    <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.enable      = en_q;
  assign bus.load_preset = lp_q;
  assign bus.addsub      = addsub_q;
  assign bus.mode_out    = mode_out_q;
  assign bus.done        = done_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl with TICK_DIV=8, HOLD=2: a terminal-detect vector
// table plus hand sequences for reset, pacing, pause/resume and button corners.
module tb_count_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  count_ctrl_if bus();

  count_ctrl #(.TICK_DIV(8), .HOLD(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] cv;
    logic        exp_addsub;
    logic [2:0]  exp_state;
    logic        exp_en;
    logic        exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One low cycle, then the level; the FSM acts on the 4th edge after the call.
  task automatic press(input bit s, input bit l);
    bus.btn_start = 1'b0;
    bus.btn_load  = 1'b0;
    step();
    bus.btn_start = s;
    bus.btn_load  = l;
    repeat (3) step();
    bus.btn_start = 1'b0;
    bus.btn_load  = 1'b0;
  endtask

  task automatic do_reset();
    bus.btn_start = 1'b0;
    bus.btn_load  = 1'b0;
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic load_to_pause(input logic [1:0] m, input logic [15:0] cv);
    bus.mode = m;
    bus.count_value = cv;
    press(1'b0, 1'b1);
    repeat (2) step();
  endtask

  initial begin
    int n;
    logic [7:0] pat;
    bit both;
    int to_run, to_pause;
    logic [2:0] prev;

    bus.btn_start = 1'b0;
    bus.btn_load = 1'b0;
    bus.mode = 2'b00;
    bus.count_value = 16'h0000;

    vecs[0] = '{2'b00, 16'h9999, 1'b1, 3'd4, 1'b0, 1'b1};
    vecs[1] = '{2'b01, 16'h9998, 1'b1, 3'd2, 1'b1, 1'b0};
    vecs[2] = '{2'b00, 16'h0000, 1'b1, 3'd2, 1'b1, 1'b0};
    vecs[3] = '{2'b10, 16'h0000, 1'b0, 3'd4, 1'b0, 1'b1};
    vecs[4] = '{2'b11, 16'h0001, 1'b0, 3'd2, 1'b1, 1'b0};
    vecs[5] = '{2'b10, 16'h9999, 1'b0, 3'd2, 1'b1, 1'b0};
    vecs[6] = '{2'b01, 16'hFFFF, 1'b1, 3'd2, 1'b1, 1'b0};
    vecs[7] = '{2'b11, 16'h00A0, 1'b0, 3'd2, 1'b1, 1'b0};

    // Reset state
    repeat (2) step();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_en", 32'(bus.enable), 32'd0);
    chk("rst_lp", 32'(bus.load_preset), 32'd0);
    chk("rst_addsub", 32'(bus.addsub), 32'd1);
    chk("rst_mode_out", 32'(bus.mode_out), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    step();

    // Start in IDLE is ignored
    press(1'b1, 1'b0);
    step();
    chk("idle_start_ign", 32'(bus.state), 32'd0);

    // Terminal-detect table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.mode = vecs[i].mode;
      bus.count_value = vecs[i].cv;
      press(1'b0, 1'b1);
      chk($sformatf("v%0d_load_state", i), 32'(bus.state), 32'd1);
      chk($sformatf("v%0d_mode_out", i), 32'(bus.mode_out), 32'(vecs[i].mode));
      chk($sformatf("v%0d_addsub", i), 32'(bus.addsub), 32'(vecs[i].exp_addsub));
      repeat (2) step();
      chk($sformatf("v%0d_pause", i), 32'(bus.state), 32'd3);
      press(1'b1, 1'b0);
      repeat (8) step();
      chk($sformatf("v%0d_state", i), 32'(bus.state), 32'(vecs[i].exp_state));
      chk($sformatf("v%0d_en", i), 32'(bus.enable), 32'(vecs[i].exp_en));
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(vecs[i].exp_done));
    end

    // DONE: start ignored, load re-enters LOAD
    do_reset();
    load_to_pause(2'b00, 16'h9999);
    press(1'b1, 1'b0);
    repeat (8) step();
    chk("done_state", 32'(bus.state), 32'd4);
    press(1'b1, 1'b0);
    step();
    chk("done_start_ign", 32'(bus.state), 32'd4);
    chk("done_still", 32'(bus.done), 32'd1);
    press(1'b0, 1'b1);
    chk("done_to_load", 32'(bus.state), 32'd1);
    chk("done_cleared", 32'(bus.done), 32'd0);

    // Load with mode=10: preset strobe exactly HOLD cycles, then PAUSE
    do_reset();
    bus.mode = 2'b10;
    bus.count_value = 16'h1234;
    press(1'b0, 1'b1);
    n = 0;
    while (bus.load_preset && n < 20) begin
      n++;
      step();
    end
    chk("lp_width", 32'(n), 32'd2);
    chk("lp_then_pause", 32'(bus.state), 32'd3);
    chk("m10_mode_out", 32'(bus.mode_out), 32'd2);
    chk("m10_addsub", 32'(bus.addsub), 32'd0);
    bus.mode = 2'b01;
    repeat (3) step();
    chk("mode_chg_ign", 32'(bus.mode_out), 32'd2);
    chk("mode_chg_addsub", 32'(bus.addsub), 32'd0);

    // Pacing: first enable 8 clk after RUN entry, 2 wide, period 8
    press(1'b1, 1'b0);
    chk("run_entry", 32'(bus.state), 32'd2);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.enable && n < 20);
    chk("first_en_lat", 32'(n), 32'd8);
    pat = '0;
    both = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      pat = {pat[6:0], bus.enable};
      if (bus.enable && bus.load_preset) both = 1'b1;
    end
    chk("en_pattern", 32'(pat), 32'h81);
    chk("en_lp_excl", 32'(both), 32'd0);

    // Load while enable is high drops it at once (next wrap rises at W+8)
    repeat (5) step();
    press(1'b0, 1'b1);
    chk("run_load_en", 32'(bus.enable), 32'd0);
    chk("run_load_lp", 32'(bus.load_preset), 32'd1);
    chk("run_load_state", 32'(bus.state), 32'd1);

    // Pause at tick 5, resume -> enable 3 cycles later
    do_reset();
    load_to_pause(2'b00, 16'h0042);
    press(1'b1, 1'b0);
    repeat (2) step();
    press(1'b1, 1'b0);
    chk("pause_state", 32'(bus.state), 32'd3);
    chk("pause_no_en", 32'(bus.enable), 32'd0);
    repeat (6) step();
    chk("pause_frozen", 32'(bus.enable), 32'd0);
    press(1'b1, 1'b0);
    chk("resume_state", 32'(bus.state), 32'd2);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.enable && n < 20);
    chk("resume_en_lat", 32'(n), 32'd3);

    // Start held 50 cycles -> one PAUSE->RUN only
    do_reset();
    load_to_pause(2'b00, 16'h0042);
    to_run = 0;
    to_pause = 0;
    prev = bus.state;
    bus.btn_start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (prev == 3'd3 && bus.state == 3'd2) to_run++;
      if (prev == 3'd2 && bus.state == 3'd3) to_pause++;
      prev = bus.state;
    end
    bus.btn_start = 1'b0;
    repeat (3) step();
    chk("held_to_run", 32'(to_run), 32'd1);
    chk("held_to_pause", 32'(to_pause), 32'd0);
    chk("held_state", 32'(bus.state), 32'd2);
    press(1'b1, 1'b0);
    chk("run_to_pause", 32'(bus.state), 32'd3);
    press(1'b1, 1'b1);
    chk("both_load_wins", 32'(bus.state), 32'd1);

    // Async reset mid-RUN with enable high
    do_reset();
    load_to_pause(2'b10, 16'h0500);
    press(1'b1, 1'b0);
    n = 0;
    while (!bus.enable && n < 20) begin
      step();
      n++;
    end
    chk("pre_rst_en", 32'(bus.enable), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_en", 32'(bus.enable), 32'd0);
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_addsub", 32'(bus.addsub), 32'd1);
    chk("arst_mode_out", 32'(bus.mode_out), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_lp", 32'(bus.load_preset), 32'd0);
    step();
    reset = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
